// File: rtl/dl_rom_loader.sv
// Byte-wide ROM download driver: unpacks the bridge's 32-bit big-endian words into paced strobes.
// Optional byte checksum on O_CSUM when DL_ROM_LOADER_CSUM_EN is defined.
module dl_rom_loader #(
  parameter int unsigned ROM_SIZE = 75040,
  parameter int unsigned WR_GAP   = 0
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic        I_START,
  input  logic [31:0] I_WDATA,
  input  logic        I_WVALID,
  output logic        O_WREADY,
  input  logic        I_END,
  output logic [16:0] O_DLADDR,
  output logic [7:0]  O_DLDATA,
  output logic        O_DLWR,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_ERR,
  output logic [15:0] O_CSUM
);

  localparam int unsigned GapW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam logic [GapW-1:0] GapInit = GapW'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic [16:0] LastAddr = 17'(ROM_SIZE - 1);
  localparam logic [16:0] AddrMax  = 17'(ROM_SIZE);

  typedef enum logic [2:0] {StIdle, StLoad, StEmit, StGap, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [2:0]        idx_q, idx_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              end_q, end_d;
  logic [16:0]       addr_q, addr_d;
  logic              dlwr_q, dlwr_d;
  logic [7:0]        dldata_q, dldata_d;
  logic              err_q, err_d;
  logic              wready_q, busy_q, done_q;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    end_d    = end_q;
    addr_d   = addr_q;
    dlwr_d   = 1'b0;
    dldata_d = dldata_q;
    err_d    = err_q;
    if (I_START) begin
      // Restart wins over any word offered in the same cycle.
      state_d = StLoad;
      addr_d  = '0;
      idx_d   = '0;
      gap_d   = '0;
      end_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StLoad: begin
          if (I_WVALID) begin
            word_d   = I_WDATA;
            idx_d    = '0;
            end_d    = I_END;
            dlwr_d   = 1'b1;
            dldata_d = I_WDATA[31:24];
            state_d  = StEmit;
          end else if (I_END) begin
            state_d = StDone;
          end
        end
        StEmit: begin
          if (addr_q != AddrMax) addr_d = addr_q + 17'd1;
          idx_d = idx_q + 3'd1;
          if (addr_q == LastAddr) begin
            state_d = StDone;
          end else if (WR_GAP > 0) begin
            state_d = StGap;
            gap_d   = GapInit;
          end else if (idx_q == 3'd3) begin
            state_d = end_q ? StDone : StLoad;
          end else begin
            dlwr_d   = 1'b1;
            dldata_d = sel_byte(word_q, idx_q[1:0] + 2'd1);
          end
        end
        StGap: begin
          if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
          end else if (idx_q[2]) begin
            state_d = end_q ? StDone : StLoad;
          end else begin
            state_d  = StEmit;
            dlwr_d   = 1'b1;
            dldata_d = sel_byte(word_q, idx_q[1:0]);
          end
        end
        StDone: begin
          if (I_WVALID) err_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= StIdle;
      word_q   <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      end_q    <= 1'b0;
      addr_q   <= '0;
      dlwr_q   <= 1'b0;
      dldata_q <= '0;
      err_q    <= 1'b0;
      wready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      end_q    <= end_d;
      addr_q   <= addr_d;
      dlwr_q   <= dlwr_d;
      dldata_q <= dldata_d;
      err_q    <= err_d;
      wready_q <= (state_d == StLoad) || (state_d == StDone);
      busy_q   <= (state_d == StLoad) || (state_d == StEmit) || (state_d == StGap);
      done_q   <= (state_d == StDone);
    end
  end

`ifdef DL_ROM_LOADER_CSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      csum_q <= '0;
    end else if (I_START) begin
      csum_q <= '0;
    end else if (dlwr_q) begin
      csum_q <= csum_q + {8'd0, dldata_q};
    end
  end

  assign O_CSUM = csum_q;
`else
  assign O_CSUM = '0;
`endif

  assign O_WREADY = wready_q;
  assign O_DLADDR = addr_q;
  assign O_DLDATA = dldata_q;
  assign O_DLWR   = dlwr_q;
  assign O_BUSY   = busy_q;
  assign O_DONE   = done_q;
  assign O_ERR    = err_q;

endmodule

// File: tb/tb_dl_rom_loader.sv
// Bench for dl_rom_loader: default, WR_GAP=2 and ROM_SIZE=6 instances share one stimulus stream.
module tb_dl_rom_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] wdata;
  logic        wvalid;
  logic        iend;

  logic        wready [3];
  logic [16:0] addr   [3];
  logic [7:0]  data   [3];
  logic        wr     [3];
  logic        busy   [3];
  logic        done   [3];
  logic        err    [3];
  logic [15:0] csum   [3];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DL_ROM_LOADER_CSUM_EN
  localparam bit CsumOn = 1'b1;
`else
  localparam bit CsumOn = 1'b0;
`endif

  dl_rom_loader u_dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_WDATA(wdata), .I_WVALID(wvalid),
    .O_WREADY(wready[0]), .I_END(iend), .O_DLADDR(addr[0]), .O_DLDATA(data[0]),
    .O_DLWR(wr[0]), .O_BUSY(busy[0]), .O_DONE(done[0]), .O_ERR(err[0]), .O_CSUM(csum[0])
  );

  dl_rom_loader #(.WR_GAP(2)) u_gap (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_WDATA(wdata), .I_WVALID(wvalid),
    .O_WREADY(wready[1]), .I_END(iend), .O_DLADDR(addr[1]), .O_DLDATA(data[1]),
    .O_DLWR(wr[1]), .O_BUSY(busy[1]), .O_DONE(done[1]), .O_ERR(err[1]), .O_CSUM(csum[1])
  );

  dl_rom_loader #(.ROM_SIZE(6)) u_small (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_WDATA(wdata), .I_WVALID(wvalid),
    .O_WREADY(wready[2]), .I_END(iend), .O_DLADDR(addr[2]), .O_DLDATA(data[2]),
    .O_DLWR(wr[2]), .O_BUSY(busy[2]), .O_DONE(done[2]), .O_ERR(err[2]), .O_CSUM(csum[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic        start;
    logic        wvalid;
    logic        iend;
    logic [31:0] wdata;
    logic        wr;
    logic [16:0] addr;
    logic [7:0]  data;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int d, input logic st, input logic wv, input logic en,
                     input logic [31:0] wd, input logic ewr, input logic [16:0] ea,
                     input logic [7:0] ed, input logic erdy, input logic ebusy,
                     input logic edone, input logic eerr);
    vec_t v;
    v.dut = d; v.start = st; v.wvalid = wv; v.iend = en; v.wdata = wd;
    v.wr = ewr; v.addr = ea; v.data = ed; v.rdy = erdy; v.busy = ebusy;
    v.done = edone; v.err = eerr;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; wvalid = 1'b0; iend = 1'b0; wdata = '0;
  endtask

  // One word through the WR_GAP=2 instance: each strobe followed by two low cycles.
  task automatic gap_word(input logic [31:0] w, input int base);
    logic [7:0] eb;
    check("gap_wready_load", 32'(wready[1]), 32'd1);
    wdata = w; wvalid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < 3; g++) begin
        step();
        wvalid = 1'b0;
        check($sformatf("gap_wr b%0d g%0d", b, g), 32'(wr[1]), 32'(g == 0));
        check($sformatf("gap_wready b%0d g%0d", b, g), 32'(wready[1]), 32'd0);
        if (g == 0) begin
          eb = 8'(w >> (8 * (3 - b)));
          check($sformatf("gap_addr b%0d", b), 32'(addr[1]), 32'(base + b));
          check($sformatf("gap_data b%0d", b), 32'(data[1]), 32'(eb));
        end
      end
    end
    step();
  endtask

  task automatic csum_word(input logic [31:0] w);
    wdata = w; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_wready%0d", d), 32'(wready[d]), 32'd0);
      check($sformatf("rst_addr%0d", d), 32'(addr[d]), 32'd0);
      check($sformatf("rst_data%0d", d), 32'(data[d]), 32'd0);
      check($sformatf("rst_wr%0d", d), 32'(wr[d]), 32'd0);
      check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      check($sformatf("rst_done%0d", d), 32'(done[d]), 32'd0);
      check($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
      check($sformatf("rst_csum%0d", d), 32'(csum[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_wready", 32'(wready[0]), 32'd0);
    check("idle_busy", 32'(busy[0]), 32'd0);

    // d  st wv en wdata         wr addr data   rdy bsy dn err
    add(0, 1, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 1, 0, 32'h11223344, 1, 0, 8'h11, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 1, 8'h22, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 2, 8'h33, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 3, 8'h44, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 4, 8'h00, 1, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0,        0, 4, 8'h00, 1, 0, 1, 0);
    add(0, 0, 1, 0, 32'hCAFEF00D, 0, 4, 8'h00, 1, 0, 1, 1);
    // ROM_SIZE=6: bytes past address 5 are dropped
    add(2, 1, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 0, 0);
    add(2, 0, 1, 0, 32'hAABBCCDD, 1, 0, 8'hAA, 0, 1, 0, 0);
    add(2, 0, 0, 0, 32'h0,        1, 1, 8'hBB, 0, 1, 0, 0);
    add(2, 0, 0, 0, 32'h0,        1, 2, 8'hCC, 0, 1, 0, 0);
    add(2, 0, 0, 0, 32'h0,        1, 3, 8'hDD, 0, 1, 0, 0);
    add(2, 0, 0, 0, 32'h0,        0, 4, 8'h00, 1, 1, 0, 0);
    add(2, 0, 1, 0, 32'hEEFF0102, 1, 4, 8'hEE, 0, 1, 0, 0);
    add(2, 0, 0, 0, 32'h0,        1, 5, 8'hFF, 0, 1, 0, 0);
    add(2, 0, 0, 0, 32'h0,        0, 6, 8'h00, 1, 0, 1, 0);
    add(2, 0, 0, 0, 32'h0,        0, 6, 8'h00, 1, 0, 1, 0);
    add(2, 0, 1, 0, 32'h12345678, 0, 6, 8'h00, 1, 0, 1, 1);
    add(2, 0, 0, 0, 32'h0,        0, 6, 8'h00, 1, 0, 1, 1);
    // I_END with the last word
    add(0, 1, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 1, 1, 32'h01020304, 1, 0, 8'h01, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 1, 8'h02, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 2, 8'h03, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 3, 8'h04, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 4, 8'h00, 1, 0, 1, 0);
    add(0, 0, 1, 0, 32'h99999999, 0, 4, 8'h00, 1, 0, 1, 1);
    // Restart from DONE, then mid-word restart with a word offered alongside
    add(0, 1, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 1, 0, 32'hA1B2C3D4, 1, 0, 8'hA1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 1, 8'hB2, 0, 1, 0, 0);
    add(0, 1, 1, 0, 32'hDEADBEEF, 0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 1, 0, 32'h55667788, 1, 0, 8'h55, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 1, 8'h66, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 2, 8'h77, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        1, 3, 8'h88, 0, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        0, 4, 8'h00, 1, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0,        0, 4, 8'h00, 1, 0, 1, 0);

    foreach (vq[i]) begin
      vec_t v;
      int d;
      v = vq[i];
      d = v.dut;
      start = v.start; wvalid = v.wvalid; iend = v.iend; wdata = v.wdata;
      step();
      check($sformatf("v%0d wr", i), 32'(wr[d]), 32'(v.wr));
      check($sformatf("v%0d addr", i), 32'(addr[d]), 32'(v.addr));
      if (v.wr) check($sformatf("v%0d data", i), 32'(data[d]), 32'(v.data));
      check($sformatf("v%0d wready", i), 32'(wready[d]), 32'(v.rdy));
      check($sformatf("v%0d busy", i), 32'(busy[d]), 32'(v.busy));
      check($sformatf("v%0d done", i), 32'(done[d]), 32'(v.done));
      check($sformatf("v%0d err", i), 32'(err[d]), 32'(v.err));
    end
    idle_inputs();

    // WR_GAP=2, two words at addresses 0..7
    start = 1'b1;
    step();
    start = 1'b0;
    gap_word(32'h0A0B0C0D, 0);
    gap_word(32'h1A1B1C1D, 4);
    check("gap_addr_end", 32'(addr[1]), 32'd8);
    check("gap_busy_end", 32'(busy[1]), 32'd1);
    iend = 1'b1;
    step();
    iend = 1'b0;
    check("gap_done", 32'(done[1]), 32'd1);
    check("gap_err", 32'(err[1]), 32'd0);

    // Checksum over 0xFFFFFFFF and 0x00000001
    start = 1'b1;
    step();
    start = 1'b0;
    check("csum_cleared", 32'(csum[0]), 32'd0);
    csum_word(32'hFFFFFFFF);
    csum_word(32'h00000001);
    iend = 1'b1;
    step();
    iend = 1'b0;
    check("csum_done", 32'(done[0]), 32'd1);
    check("csum_value", 32'(csum[0]), CsumOn ? 32'h03FD : 32'h0);
    step();
    check("csum_hold", 32'(csum[0]), CsumOn ? 32'h03FD : 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("csum_restart", 32'(csum[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dl_rom_loader.md
Name: dl_rom_loader

Overview:
- Download-side driver for the core's ROM/PROM banks: turns the bridge's 32-bit word stream into the byte-wide bus that every ROM module's download port decodes (address, data, write strobe).
- Sits between the host data bridge and the ROM modules.
- Sequences addresses 0x00000 upward through the ROM map.
- Paces write strobes and reports busy, done and error status to the core's reset and hold logic.

Parameters:
- ROM_SIZE, 75040 (0x12520): total bytes in the ROM map; last writable address is ROM_SIZE-1.
- WR_GAP, 0: idle cycles inserted after each write strobe (0 gives back-to-back strobes).

Ports:
- I_CLK  in  1  single clock for the block and for the ROM download ports.
- I_RST_N  in  1  asynchronous active-low reset.
- I_START  in  1  one-cycle pulse; begins or restarts a load.
- I_WDATA  in  32  stream word; big-endian (bits 31:24 form the first byte).
- I_WVALID  in  1  stream word valid.
- O_WREADY  out  1  stream word ready.
- I_END  in  1  host has no more words (level, sampled in LOAD).
- O_DLADDR  out  17  byte address to the ROM modules.
- O_DLDATA  out  8  byte data to the ROM modules.
- O_DLWR  out  1  write strobe, one cycle per byte.
- O_BUSY  out  1  load in progress.
- O_DONE  out  1  load finished (sticky until I_START or reset).
- O_ERR  out  1  sticky overflow flag.
- O_CSUM  out  16  byte checksum (see Optional Feature).

Behaviour:
- Reset (async, I_RST_N=0):
  - State IDLE.
  - All outputs 0, including O_DLADDR and O_CSUM.
  - Internal byte index, gap counter and end latch cleared.
- States: IDLE, LOAD, EMIT, GAP, DONE.
- IDLE:
  - O_WREADY=0; I_WVALID is ignored.
  - I_START moves to LOAD, O_DLADDR=0, O_BUSY=1.
- LOAD:
  - O_WREADY=1.
  - Handshake: a word transfers on a rising edge with I_WVALID=1 and O_WREADY=1. The word is latched, byte index set to 0, next state EMIT.
  - If I_END=1 and I_WVALID=0: go to DONE.
  - If I_END=1 and I_WVALID=1 in the same cycle: accept the word, latch end, go to DONE after its bytes are emitted.
- EMIT:
  - O_WREADY=0.
  - O_DLWR=1 for exactly one cycle with O_DLDATA = byte[index] and the current O_DLADDR.
  - On the following edge: O_DLADDR increments and index increments.
  - Next state is GAP if WR_GAP>0; otherwise EMIT for the next byte.
  - After byte 3: next state is LOAD, or DONE if end is latched.
- GAP:
  - O_DLWR=0 for exactly WR_GAP cycles.
  - Then return to EMIT, or to LOAD/DONE after byte 3.
- Latency:
  - Word accepted at edge N; first strobe is visible in cycle N+1.
  - With WR_GAP=0 a word takes 4 strobe cycles plus 1 LOAD cycle, i.e. 5 cycles per word at full rate.
- O_DLADDR and O_DLDATA are stable for the whole strobe cycle. O_DLADDR holds its value between strobes.
- Full boundary:
  - When a strobe writes address ROM_SIZE-1, the remaining bytes of that word are dropped (no strobe) and the state becomes DONE.
  - O_DLADDR saturates at ROM_SIZE and never wraps to 0.
- DONE:
  - O_BUSY=0, O_DONE=1, O_DLWR=0.
  - O_WREADY=1 so the bridge drains without stalling.
  - Any word accepted in DONE is discarded and sets O_ERR=1.
- I_START in any state (including mid-word or mid-gap):
  - Next cycle O_DLWR=0, O_DLADDR=0, O_DONE=0, O_ERR=0, O_CSUM=0, end latch cleared, state LOAD.
  - A word presented in the same cycle as I_START is not accepted.
- O_BUSY=1 in LOAD, EMIT and GAP; 0 otherwise.

Optional Feature:
- Macro: DL_ROM_LOADER_CSUM_EN.
- Defined:
  - O_CSUM is a 16-bit modulo-2^16 sum of every byte actually strobed (dropped bytes are not counted).
  - It updates on the edge ending each strobe cycle.
  - Cleared by reset and by I_START; holds its value in DONE.
- Undefined:
  - O_CSUM is constant 0 and no adder is instantiated.
  - All other behaviour is identical.

Test Plan:
- Reset, I_START, one word 0x11223344 with WR_GAP=0, then I_END -> strobes at addresses 0..3 with data 0x11, 0x22, 0x33, 0x44 on consecutive cycles; first strobe 1 cycle after acceptance; O_DONE=1; O_DLADDR=4.
- WR_GAP=2, two words -> each O_DLWR pulse is followed by exactly 2 low cycles; O_WREADY is low throughout EMIT/GAP; addresses run 0..7.
- ROM_SIZE=6, two words 0xAABBCCDD and 0xEEFF0102 -> six strobes (last at address 5, data 0xFF); bytes 0x01 and 0x02 are not strobed; DONE with O_DLADDR=6; a third word then sets O_ERR=1.
- I_END and I_WVALID high together with word 0x01020304 -> all 4 bytes are written, then DONE; no further O_WREADY stall.
- I_START pulsed during the second strobe of a word -> next cycle O_DLWR=0, O_DLADDR=0; the next word is written starting at address 0; O_ERR and O_DONE are cleared.
- With DL_ROM_LOADER_CSUM_EN, words 0xFFFFFFFF and 0x00000001 -> O_CSUM=0x03FD; without the macro, O_CSUM=0.
